// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmitter slice: FSM state encoding and
// the default baud divisor used by both the host top and the bench.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // 100 MHz system clock / 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned BAUD_CW              = 16;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO with registered count, full/empty and a
// one-cycle overflow pulse for writes dropped while full.
module sync_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          overflow_o,
    output logic [AW:0]   count_o
);

    localparam int unsigned DEPTH = 2**AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          overflow_q;
    logic          pop_ok_s;
    logic          push_ok_s;

    // A pop in the same cycle frees a slot, so a write at full still lands.
    assign pop_ok_s  = pop_i & ~empty_q;
    assign push_ok_s = push_i & (~full_q | pop_ok_s);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and the registered status flags.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            full_q     <= (count_d == (AW+1)'(DEPTH));
            empty_q    <= (count_d == {(AW+1){1'b0}});
            overflow_q <= push_i & full_q & ~pop_ok_s;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o     = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = overflow_q;
    assign count_o    = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; frames go out back-to-back
// while the FIFO has data, and txd is always driven from a flop.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       wr,
    input  logic [7:0] data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       txd
);

    tx_state_e          state_q;
    logic [BAUD_CW-1:0] baud_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               txd_q;
    logic               busy_q;
    logic               baud_last_s;
    logic               has_data_s;
    logic               pop_s;
    logic [7:0]         fifo_dout_s;
    logic [FIFO_AW:0]   fifo_count_s;

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk        (clk),
        .nreset     (nreset),
        .push_i     (wr),
        .din_i      (data),
        .pop_i      (pop_s),
        .dout_o     (fifo_dout_s),
        .full_o     (full),
        .empty_o    (empty),
        .overflow_o (overflow),
        .count_o    (fifo_count_s)
    );

    assign baud_last_s = (baud_q == BAUD_CW'(CLKS_PER_BIT - 1));
    assign has_data_s  = (fifo_count_s != {(FIFO_AW+1){1'b0}});
    // Pop from IDLE, or on the final stop cycle to chain the next frame.
    assign pop_s = has_data_s &
                   ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_last_s));

    // Transmit FSM with baud counter, bit index, shifter and output flops.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            baud_q  <= {BAUD_CW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= {BAUD_CW{1'b0}};
                    if (pop_s) begin
                        shift_q <= fifo_dout_s;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end else begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_last_s) begin
                        baud_q  <= {BAUD_CW{1'b0}};
                        bit_q   <= 3'd0;
                        txd_q   <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_CW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last_s) begin
                        baud_q <= {BAUD_CW{1'b0}};
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_CW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_last_s) begin
                        baud_q <= {BAUD_CW{1'b0}};
                        if (pop_s) begin
                            shift_q <= fifo_dout_s;
                            txd_q   <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_CW'(1);
                    end
                end
                default: begin
                    baud_q  <= {BAUD_CW{1'b0}};
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: small-divisor instance for framing/FIFO scenarios and a
// default-divisor instance for the real baud period.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int CPB = 4;
    localparam int AW  = 2;
    localparam int DEF = CLKS_PER_BIT_DEFAULT;

    logic       clk    = 1'b0;
    logic       nreset = 1'b0;
    logic       wr     = 1'b0;
    logic [7:0] data   = 8'h00;
    logic       full, empty, busy, overflow, txd;
    logic       wr_d   = 1'b0;
    logic [7:0] data_d = 8'h00;
    logic       full_d, empty_d, busy_d, overflow_d, txd_d;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk(clk), .nreset(nreset), .wr(wr), .data(data), .full(full),
        .empty(empty), .busy(busy), .overflow(overflow), .txd(txd)
    );

    uart_tx_fifo dut_def (
        .clk(clk), .nreset(nreset), .wr(wr_d), .data(data_d), .full(full_d),
        .empty(empty_d), .busy(busy_d), .overflow(overflow_d), .txd(txd_d)
    );

    // Expected line level at cycle c of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int c, input int cpb);
        int k;
        k = c / cpb;
        if (k == 0) return 1'b0;
        else if (k >= 9) return 1'b1;
        else return b[k-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        tick();
        tick();
        for (int pass = 0; pass < 2; pass++) begin
            if ({txd, busy, full, empty, overflow} !== 5'b10010) begin
                $display("FAIL reset_state pass=%0d got=%b exp=10010", pass,
                         {txd, busy, full, empty, overflow});
                n_err++;
            end
            n_vec++;
            if ({txd_d, busy_d, full_d, empty_d, overflow_d} !== 5'b10010) begin
                $display("FAIL reset_state_def pass=%0d got=%b exp=10010", pass,
                         {txd_d, busy_d, full_d, empty_d, overflow_d});
                n_err++;
            end
            n_vec++;
            nreset = 1'b1;
            tick();
        end
    endtask

    task automatic test_single_byte();
        wr = 1'b1; data = 8'hA5;
        tick();
        wr = 1'b0;
        if ({txd, busy, empty} !== 3'b100) begin
            $display("FAIL single_write_edge got=%b exp=100", {txd, busy, empty});
            n_err++;
        end
        n_vec++;
        tick();
        for (int c = 0; c < 10*CPB; c++) begin
            if (txd !== frame_bit(8'hA5, c, CPB) || busy !== 1'b1) begin
                $display("FAIL single_frame c=%0d got txd=%b busy=%b exp txd=%b busy=1",
                         c, txd, busy, frame_bit(8'hA5, c, CPB));
                n_err++;
            end
            n_vec++;
            if (c == 0 && empty !== 1'b1) begin
                $display("FAIL single_empty_after_pop got=%b exp=1", empty);
                n_err++;
            end
            tick();
        end
        if ({txd, busy, empty} !== 3'b101) begin
            $display("FAIL single_end got=%b exp=101", {txd, busy, empty});
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_burst_to_full();
        logic [7:0] b;
        wr = 1'b1; data = 8'h01; tick();
        data = 8'h02; tick();
        for (int c = 0; c < 50*CPB; c++) begin
            if (c < 3) begin wr = 1'b1; data = 8'(c + 3); end
            else wr = 1'b0;
            b = 8'(c / (10*CPB) + 1);
            if (txd !== frame_bit(b, c % (10*CPB), CPB) || busy !== 1'b1 || overflow !== 1'b0) begin
                $display("FAIL burst_frame c=%0d got txd=%b busy=%b ovf=%b exp txd=%b busy=1 ovf=0",
                         c, txd, busy, overflow, frame_bit(b, c % (10*CPB), CPB));
                n_err++;
            end
            n_vec++;
            if (c == 3) begin
                if (full !== 1'b1) begin
                    $display("FAIL burst_full got=%b exp=1", full);
                    n_err++;
                end
                n_vec++;
            end
            tick();
        end
        if ({txd, busy, empty} !== 3'b101) begin
            $display("FAIL burst_end got=%b exp=101", {txd, busy, empty});
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        wr = 1'b1; data = 8'h11; tick();
        data = 8'h12; tick();
        for (int c = 0; c < 50*CPB; c++) begin
            if (c < 3) begin wr = 1'b1; data = 8'(c + 8'h13); end
            else if (c == 3) begin wr = 1'b1; data = 8'hFF; end
            else wr = 1'b0;
            b = 8'(c / (10*CPB) + 8'h11);
            if (txd !== frame_bit(b, c % (10*CPB), CPB)) begin
                $display("FAIL ovf_frame c=%0d got=%b exp=%b", c, txd,
                         frame_bit(b, c % (10*CPB), CPB));
                n_err++;
            end
            n_vec++;
            if (overflow !== (c == 4)) begin
                $display("FAIL ovf_pulse c=%0d got=%b exp=%b", c, overflow, (c == 4));
                n_err++;
            end
            n_vec++;
            if (c == 4 && full !== 1'b1) begin
                $display("FAIL ovf_full got=%b exp=1", full);
                n_err++;
            end
            tick();
        end
        if ({txd, busy, empty} !== 3'b101) begin
            $display("FAIL ovf_end got=%b exp=101", {txd, busy, empty});
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_write_pop_full();
        logic [7:0] b;
        wr = 1'b1; data = 8'h21; tick();
        data = 8'h22; tick();
        for (int c = 0; c < 60*CPB; c++) begin
            if (c < 3) begin wr = 1'b1; data = 8'(c + 8'h23); end
            else if (c == 10*CPB - 1) begin wr = 1'b1; data = 8'h26; end
            else wr = 1'b0;
            b = 8'(c / (10*CPB) + 8'h21);
            if (txd !== frame_bit(b, c % (10*CPB), CPB) || overflow !== 1'b0) begin
                $display("FAIL wpf_frame c=%0d got txd=%b ovf=%b exp txd=%b ovf=0",
                         c, txd, overflow, frame_bit(b, c % (10*CPB), CPB));
                n_err++;
            end
            n_vec++;
            if (c == 10*CPB - 1 || c == 10*CPB) begin
                if (full !== 1'b1) begin
                    $display("FAIL wpf_full c=%0d got=%b exp=1", c, full);
                    n_err++;
                end
                n_vec++;
            end
            tick();
        end
        if ({txd, busy, empty} !== 3'b101) begin
            $display("FAIL wpf_end got=%b exp=101", {txd, busy, empty});
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_reset_mid_frame();
        wr = 1'b1; data = 8'h3C; tick();
        data = 8'hA1; tick();
        data = 8'hA2; tick();
        wr = 1'b0;
        for (int c = 1; c < 17; c++) tick();
        if ({txd, busy, empty} !== 3'b110) begin
            $display("FAIL rst_pre_bit3 got=%b exp=110", {txd, busy, empty});
            n_err++;
        end
        n_vec++;
        #2 nreset = 1'b0;
        #1;
        if ({txd, busy, empty, full} !== 4'b1010) begin
            $display("FAIL rst_async got=%b exp=1010", {txd, busy, empty, full});
            n_err++;
        end
        n_vec++;
        #2 nreset = 1'b1;
        for (int c = 0; c < 25*CPB; c++) begin
            tick();
            if ({txd, busy, empty} !== 3'b101) begin
                $display("FAIL rst_after c=%0d got=%b exp=101", c, {txd, busy, empty});
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_default_baud();
        wr_d = 1'b1; data_d = 8'h55; tick();
        wr_d = 1'b0; tick();
        for (int c = 0; c < 10*DEF; c++) begin
            if (txd_d !== frame_bit(8'h55, c, DEF) || busy_d !== 1'b1) begin
                $display("FAIL def_baud c=%0d got txd=%b busy=%b exp txd=%b busy=1",
                         c, txd_d, busy_d, frame_bit(8'h55, c, DEF));
                n_err++;
            end
            n_vec++;
            tick();
        end
        if ({txd_d, busy_d} !== 2'b10) begin
            $display("FAIL def_end got=%b exp=10", {txd_d, busy_d});
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_to_full();
        test_overflow();
        test_write_pop_full();
        test_reset_mid_frame();
        test_default_baud();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-wide UART transmitter (8N1) with an input FIFO.
- Sits between the host's Z80 I/O-write decode and the board pin UART_TXD.
- Absorbs bursts of writes from the CPU and serialises them at a fixed baud rate.
- Reports full/empty/busy status for the CPU-readable status port.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- wr  in  1  write strobe; one byte is enqueued per clk cycle in which wr=1 and full=0.
- data  in  8  byte to enqueue, sampled with wr.
- full  out  1  FIFO holds 2**FIFO_AW bytes.
- empty  out  1  FIFO holds 0 bytes.
- busy  out  1  a frame is being shifted out (state != IDLE).
- overflow  out  1  single-cycle pulse: wr=1 while full=1 (byte dropped).
- txd  out  1  serial output, idle high.

Behaviour:
- Reset (async, nreset=0):
  - txd=1, busy=0, full=0, empty=1, overflow=0.
  - FIFO pointers and count cleared; state=IDLE; bit/baud counters 0.
  - Reset asserted mid-frame aborts the frame immediately (txd=1 without waiting for a clock edge) and flushes the FIFO.
- FIFO:
  - Synchronous write and read, registered count 0..2**FIFO_AW.
  - full/empty are registered and decoded from the count.
  - Write with full=1 is ignored and overflow pulses for exactly 1 cycle.
  - Simultaneous write and pop:
    - count unchanged, both operations take effect.
    - Legal when full=1 only if a pop occurs in the same cycle; this write is accepted and overflow=0.
  - Pointers wrap modulo depth.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If empty=0, pop head byte into the shift register, go to START. Pop and state change happen on the same edge.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit; after bit 7 go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
    - On the last stop cycle, if empty=0, pop the next byte and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency:
  - wr asserted at edge N with FIFO empty and FSM in IDLE: the byte is visible at edge N, popped at edge N+1, and txd falls at edge N+1 (registered output).
  - empty returns to 1 at edge N+1.
- The baud counter resets to 0 on every state/bit transition. No fractional-rate accumulation.
- txd is driven from a flop; no combinational path to the pin.
- busy=1 from the edge entering START until the edge entering IDLE.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, 2 bits);
  - the default CLKS_PER_BIT constant, so the host top and the bench use the same value.
- One natural sub-module: sync_fifo (parameterised data width and FIFO_AW; outputs full, empty, count). uart_tx_fifo instantiates it and contains only the FSM and baud counter.

Test Plan (bench runs CLKS_PER_BIT=4, FIFO_AW=2 unless noted):
1. Single byte: write 0xA5 while idle -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. txd falls 1 edge after the write edge; busy deasserts 40 cycles after the fall.
2. Burst to full: write 0x01..0x05 in 5 consecutive cycles.
   - First byte is popped immediately; the remaining 4 fill the FIFO, so full=1.
   - No overflow.
   - Five frames follow back-to-back with no idle cycles between stop and start.
   - Total time 200 cycles.
3. Overflow: with FIFO full and no pop pending, write 0xFF -> overflow=1 for one cycle, count unchanged, 0xFF never appears on txd.
4. Write+pop same cycle at full: time a write to the last stop cycle of a frame -> write accepted, full stays 1, overflow=0, byte transmitted in order.
5. Reset mid-frame: assert nreset=0 during DATA bit 3 of 0x3C with 2 bytes queued.
   - txd=1 immediately; empty=1, busy=0.
   - After release, txd stays 1 indefinitely.
6. Default baud: CLKS_PER_BIT=868, write 0x55 -> each bit measured at exactly 868 cycles (8.68 µs at 100 MHz).
